// File: rtl/dmem_resp.sv
// dmem_resp: one-cycle-latency data RAM plus a four-register MMIO window
// (cycle, tohost, errcnt, scratch) for the core data port.
module dmem_resp #(
   parameter int          AW         = 8,
   parameter logic [31:0] TOHOST_RST = 32'h0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] dat_a,
   input  logic [3:0]  dat_we,
   input  logic [31:0] dat_wd,
   input  logic [3:0]  dat_re,
   output logic [31:0] dat_rd,
   output logic        done,
   output logic [31:0] tohost
);

   localparam int DEPTH = 1 << AW;

   logic          r_sel;
   logic [AW-1:0] r_idx;
   logic [3:0]    r_we;
   logic [3:0]    r_re;
   logic [31:0]   r_wd;

   logic [31:0]   r_mem [DEPTH];
   logic [31:0]   r_cycle;
   logic [31:0]   r_cyc_snap;
   logic [31:0]   r_tohost;
   logic [31:0]   r_errcnt;
   logic [31:0]   r_scratch;
   logic [31:0]   r_hold;
   logic          r_done;

   logic [31:0]   w_mmio;
   logic [31:0]   w_word;
   logic [31:0]   w_wmerge;
   logic          w_wr;
   logic          w_rd;
   logic          w_ro;
   logic          w_err;
   logic          w_unused_a;

   // Aliased address bits and the byte offset are intentionally dropped.
   assign w_unused_a = ^{dat_a[14:2], dat_a[1:0]};

   assign w_wr  = |r_we;
   assign w_rd  = |r_re;
   assign w_ro  = r_sel & ~r_idx[0];
   assign w_err = (w_wr & w_rd) | (w_wr & w_ro);

   assign done   = r_done;
   assign tohost = r_tohost;

   // Register the request; only the enables are cleared by reset.
   always_ff @(posedge clk) begin
      r_sel <= dat_a[15];
      r_idx <= dat_a[AW+1:2];
      r_wd  <= dat_wd;
      if (!rstn) begin
         r_we <= 4'h0;
         r_re <= 4'h0;
      end else begin
         r_we <= dat_we;
         r_re <= dat_re;
      end
   end

   // Select the addressed MMIO register; cycle reads the captured count.
   always_comb begin
      w_mmio = r_cyc_snap;
      case (r_idx[1:0])
         2'd0: w_mmio = r_cyc_snap;
         2'd1: w_mmio = r_tohost;
         2'd2: w_mmio = r_errcnt;
         2'd3: w_mmio = r_scratch;
         default: w_mmio = r_cyc_snap;
      endcase
   end

   // Current word at the registered address.
   assign w_word = r_sel ? w_mmio : r_mem[r_idx];

   // Byte-merge write data into the current word.
   always_comb begin
      w_wmerge = w_word;
      for (int k = 0; k < 4; k++) begin
         if (r_we[k]) w_wmerge[8*k +: 8] = r_wd[8*k +: 8];
      end
   end

   // Read lanes come from the word; disabled lanes hold the last output.
   always_comb begin
      dat_rd = r_hold;
      for (int k = 0; k < 4; k++) begin
         if (r_re[k]) dat_rd[8*k +: 8] = w_word[8*k +: 8];
      end
   end

   // Remember the visible read data so idle lanes keep their value.
   always_ff @(posedge clk) begin
      if (!rstn) r_hold <= 32'h0;
      else       r_hold <= dat_rd;
   end

   // RAM write commit; a write pending at a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (rstn && w_wr && !r_sel) r_mem[r_idx] <= w_wmerge;
   end

   // MMIO state: counters, writable registers and the sticky done flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cycle    <= 32'h0;
         r_cyc_snap <= 32'h0;
         r_errcnt   <= 32'h0;
         r_scratch  <= 32'h0;
         r_tohost   <= TOHOST_RST;
         r_done     <= 1'b0;
      end else begin
         r_cycle    <= r_cycle + 32'd1;
         r_cyc_snap <= r_cycle;
         if (w_err && (r_errcnt != 32'hFFFF_FFFF))
            r_errcnt <= r_errcnt + 32'd1;
         if (w_wr && r_sel && (r_idx[1:0] == 2'd1)) begin
            r_tohost <= w_wmerge;
            if (w_wmerge[0]) r_done <= 1'b1;
         end
         if (w_wr && r_sel && (r_idx[1:0] == 2'd3))
            r_scratch <= w_wmerge;
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed vector table plus hand sequences for done,
// reset-while-busy and post-reset cycle counting.
module tb_dmem_resp;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] dat_a = 16'h0;
   logic [3:0]  dat_we = 4'h0;
   logic [31:0] dat_wd = 32'h0;
   logic [3:0]  dat_re = 4'h0;
   logic [31:0] dat_rd;
   logic        done;
   logic [31:0] tohost;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   dmem_resp #(.AW(8), .TOHOST_RST(32'h0)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .dat_a  (dat_a),
      .dat_we (dat_we),
      .dat_wd (dat_wd),
      .dat_re (dat_re),
      .dat_rd (dat_rd),
      .done   (done),
      .tohost (tohost)
   );

   typedef struct {
      logic [15:0] a;
      logic [3:0]  we;
      logic [31:0] wd;
      logic [3:0]  re;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [21];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Called at a falling edge; returns the response one cycle later.
   task automatic op(input logic [15:0] a, input logic [3:0] we,
                     input logic [31:0] wd, input logic [3:0] re,
                     output logic [31:0] rd);
      dat_a  = a;
      dat_we = we;
      dat_wd = wd;
      dat_re = re;
      @(negedge clk);
      rd     = dat_rd;
      dat_we = 4'h0;
      dat_re = 4'h0;
   endtask

   task automatic idle();
      dat_we = 4'h0;
      dat_re = 4'h0;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;

      // Vector i is captured at the i-th edge after release, so a cycle
      // read in slot i returns i.
      tbl[0]  = '{16'h8000, 4'h0, 32'h0,        4'hF, 32'h0000_0000};
      tbl[1]  = '{16'h0040, 4'hF, 32'hDEADBEEF, 4'h0, 32'h0000_0000};
      tbl[2]  = '{16'h0040, 4'h0, 32'h0,        4'hF, 32'hDEADBEEF};
      tbl[3]  = '{16'h0010, 4'hF, 32'h11223344, 4'h0, 32'hDEADBEEF};
      tbl[4]  = '{16'h0010, 4'h4, 32'h00CC0000, 4'h0, 32'hDEADBEEF};
      tbl[5]  = '{16'h0010, 4'h0, 32'h0,        4'hF, 32'h11CC3344};
      tbl[6]  = '{16'h0040, 4'h0, 32'h0,        4'h1, 32'h11CC33EF};
      tbl[7]  = '{16'h0020, 4'hF, 32'h5,        4'h0, 32'h11CC33EF};
      tbl[8]  = '{16'h0020, 4'hF, 32'h9,        4'hF, 32'h0000_0005};
      tbl[9]  = '{16'h0020, 4'h0, 32'h0,        4'hF, 32'h0000_0009};
      tbl[10] = '{16'h8008, 4'h0, 32'h0,        4'hF, 32'h0000_0001};
      tbl[11] = '{16'h0400, 4'hF, 32'hA5,       4'h0, 32'h0000_0001};
      tbl[12] = '{16'h0000, 4'h0, 32'h0,        4'hF, 32'h0000_00A5};
      tbl[13] = '{16'h8000, 4'hF, 32'h1234,     4'h0, 32'h0000_00A5};
      tbl[14] = '{16'h8008, 4'h0, 32'h0,        4'hF, 32'h0000_0002};
      tbl[15] = '{16'h800C, 4'hF, 32'hCAFEF00D, 4'h0, 32'h0000_0002};
      tbl[16] = '{16'h800C, 4'h0, 32'h0,        4'hC, 32'hCAFE_0002};
      tbl[17] = '{16'h8004, 4'h0, 32'h0,        4'hF, 32'h0000_0000};
      tbl[18] = '{16'h8000, 4'h0, 32'h0,        4'hF, 32'h0000_0012};
      tbl[19] = '{16'h8008, 4'hF, 32'hFFFFFFFF, 4'h0, 32'h0000_0012};
      tbl[20] = '{16'h8008, 4'h0, 32'h0,        4'hF, 32'h0000_0003};

      repeat (3) @(negedge clk);
      check("rst_dat_rd", dat_rd, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_tohost", tohost, 32'h0);

      rstn = 1'b1;
      for (int i = 0; i < 21; i++) begin
         op(tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].re, rd);
         check($sformatf("vec%0d", i), rd, tbl[i].exp);
      end

      // done is set only by a tohost write with bit0=1, and is sticky.
      op(16'h8004, 4'hF, 32'h2, 4'h0, rd);
      idle();
      check("done_after_2", {31'h0, done}, 32'h0);
      check("tohost_2", tohost, 32'h2);
      op(16'h8004, 4'hF, 32'h1, 4'h0, rd);
      check("done_n1", {31'h0, done}, 32'h0);
      idle();
      check("done_n2", {31'h0, done}, 32'h1);
      check("tohost_1", tohost, 32'h1);
      op(16'h8004, 4'hF, 32'h0, 4'h0, rd);
      idle();
      check("done_sticky", {31'h0, done}, 32'h1);
      check("tohost_0", tohost, 32'h0);

      // A store still pending at a reset edge must not commit.
      op(16'h0030, 4'hF, 32'h11, 4'h0, rd);
      dat_a  = 16'h0030;
      dat_we = 4'hF;
      dat_wd = 32'h77;
      @(negedge clk);
      dat_we = 4'h0;
      rstn   = 1'b0;
      @(negedge clk);
      check("mid_rst_dat_rd", dat_rd, 32'h0);
      check("mid_rst_done", {31'h0, done}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      op(16'h8000, 4'h0, 32'h0, 4'hF, rd);
      check("cycle_first", rd, 32'h0);
      op(16'h8008, 4'h0, 32'h0, 4'hF, rd);
      check("errcnt_rst", rd, 32'h0);
      op(16'h0030, 4'h0, 32'h0, 4'hF, rd);
      check("ram_no_commit", rd, 32'h11);
      op(16'h8000, 4'h0, 32'h0, 4'hF, rd);
      check("cycle_third", rd, 32'h3);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
